// File: rtl/sr_pkg.sv
// Shared SR flip-flop definitions: the S=R=1 resolution policies and the
// per-bit next-state function.
package sr_pkg;

    localparam int unsigned POL_HOLD   = 0;
    localparam int unsigned POL_SET    = 1;
    localparam int unsigned POL_RST    = 2;
    localparam int unsigned POL_TOGGLE = 3;

    function automatic logic sr_next(
        input logic        q,
        input logic        s,
        input logic        r,
        input int unsigned policy
    );
        logic nxt;
        nxt = q;
        unique case ({s, r})
            2'b00: nxt = q;
            2'b10: nxt = 1'b1;
            2'b01: nxt = 1'b0;
            default: begin
                case (policy)
                    POL_SET:    nxt = 1'b1;
                    POL_RST:    nxt = 1'b0;
                    POL_TOGGLE: nxt = ~q;
                    default:    nxt = q;
                endcase
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_bit.sv
// One SR storage bit; q updates one cycle after s/r are sampled, no backpressure.
// q_bar is the inverse of the same register so the pair can never be equal.
module sr_bit
    import sr_pkg::*;
#(
    parameter logic        RESET_VAL   = 1'b0,
    parameter int unsigned BOTH_POLICY = POL_HOLD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    input  logic r,
    output logic q,
    output logic q_bar
);

    logic state_q;
    logic state_d;

    always_comb begin
        state_d = sr_next(state_q, s, r, BOTH_POLICY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign q     = state_q;
    assign q_bar = ~state_q;

endmodule

// File: rtl/sr_flipflop.sv
// WIDTH independent SR flip-flops sharing clock and async reset.
// One-cycle latency from s/r to q; no flow control, accepts s/r every cycle.
module sr_flipflop
    import sr_pkg::*;
#(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int unsigned      BOTH_POLICY = POL_HOLD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
);

    if (BOTH_POLICY > POL_TOGGLE) begin : g_bad_policy
        $error("sr_flipflop: BOTH_POLICY=%0d is outside 0..3", BOTH_POLICY);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sr_bit #(
            .RESET_VAL   (RESET_VAL[i]),
            .BOTH_POLICY (BOTH_POLICY)
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .s     (s[i]),
            .r     (r[i]),
            .q     (q[i]),
            .q_bar (q_bar[i])
        );
    end

    // Unknown requests would silently corrupt the stored flag.
    a_sr_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown({s, r}))
        else $error("sr_flipflop: X/Z on s or r at a sampling edge");

endmodule

// File: tb/tb_sr_flipflop.sv
// Directed bench: four single-bit instances (one per S=R=1 policy) and one
// 4-bit hold-policy instance, checked against a scoreboard of expected states.
module tb_sr_flipflop;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sp, rp, qp, qbp;
    logic [3:0] sw, rw, qw, qbw;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 4; i++) begin : g_pol
        sr_flipflop #(
            .WIDTH       (1),
            .RESET_VAL   (1'b0),
            .BOTH_POLICY (i)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .s     (sp[i]),
            .r     (rp[i]),
            .q     (qp[i]),
            .q_bar (qbp[i])
        );
    end

    sr_flipflop #(
        .WIDTH       (4),
        .RESET_VAL   (4'b0000),
        .BOTH_POLICY (0)
    ) u_wide (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (sw),
        .r     (rw),
        .q     (qw),
        .q_bar (qbw)
    );

    typedef struct {
        string      tag;
        int         idx;
        logic [3:0] exp;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] mp, mw;
    int         checks   = 0;
    int         failures = 0;

    function automatic logic ref_bit(input logic q, input logic s, input logic r, input int pol);
        if (s && !r) return 1'b1;
        if (!s && r) return 1'b0;
        if (!s && !r) return q;
        if (pol == 1) return 1'b1;
        if (pol == 2) return 1'b0;
        if (pol == 3) return ~q;
        return q;
    endfunction

    task automatic push(input string tag);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.tag = tag;
            e.idx = i;
            e.exp = {3'b000, mp[i]};
            sb.push_back(e);
        end
        e.tag = tag;
        e.idx = 4;
        e.exp = mw;
        sb.push_back(e);
    endtask

    task automatic drive(input string tag, input logic [3:0] s_pol, input logic [3:0] r_pol,
                         input logic [3:0] s_w, input logic [3:0] r_w);
        sp = s_pol;
        rp = r_pol;
        sw = s_w;
        rw = r_w;
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 4; i++) mp[i] = ref_bit(mp[i], s_pol[i], r_pol[i], i);
            for (int i = 0; i < 4; i++) mw[i] = ref_bit(mw[i], s_w[i], r_w[i], 0);
        end else begin
            mp = 4'b0000;
            mw = 4'b0000;
        end
        push(tag);
    endtask

    task automatic check_sb();
        exp_t       e;
        logic [3:0] obs, obs_b, exp_b;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.idx == 4) begin
                obs   = qw;
                obs_b = qbw;
                exp_b = ~e.exp;
            end else begin
                obs   = {3'b000, qp[e.idx]};
                obs_b = {3'b000, qbp[e.idx]};
                exp_b = {3'b000, ~e.exp[0]};
            end
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s q[dut%0d] observed=%b expected=%b", e.tag, e.idx, obs, e.exp);
            end
            checks++;
            assert (obs_b === exp_b) else begin
                failures++;
                $error("FAIL %s q_bar[dut%0d] observed=%b expected=%b", e.tag, e.idx, obs_b, exp_b);
            end
        end
    endtask

    task automatic edge_check();
        @(posedge clk);
        #1;
        check_sb();
    endtask

    initial begin
        rst_n = 1'b0;
        mp    = 4'b0000;
        mw    = 4'b0000;
        drive("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        #1 check_sb();
        drive("reset_edge", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        edge_check();

        #4 rst_n = 1'b1;
        #10 drive("set", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        edge_check();
        #4 drive("clear", 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        edge_check();
        #4 drive("hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        edge_check();
        #4 drive("both", 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        edge_check();
        #4 drive("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        edge_check();

        // Async reset well away from any clock edge.
        #4 drive("preset", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        edge_check();
        #2 rst_n = 1'b0;
        mp = 4'b0000;
        mw = 4'b0000;
        push("async_rst");
        #1 check_sb();
        #1 rst_n = 1'b1;
        drive("post_rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        edge_check();

        #4 drive("policy_both", 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        edge_check();
        #4 drive("toggle_again", 4'b1000, 4'b1000, 4'b0000, 4'b0000);
        edge_check();

        #4 drive("wide_mix", 4'b0000, 4'b0000, 4'b1010, 4'b0110);
        edge_check();
        #4 drive("wide_set", 4'b0000, 4'b0000, 4'b0101, 4'b0000);
        edge_check();
        #4 drive("wide_both", 4'b0000, 4'b0000, 4'b1111, 4'b1111);
        edge_check();
        #4 drive("wide_clr", 4'b0000, 4'b0000, 4'b0000, 4'b1001);
        edge_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
